// File: rtl/sync_mem_if.sv
// ----------------------------------------------------------------------------
// sync_mem_if : access bus for the synchronous program/data RAM.
// Groups the address, write, read-strobe, output-enable and status signals.
// 'data' is the shared tri-state read bus driven by the memory.
// ----------------------------------------------------------------------------
interface sync_mem_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic              oe_n;
    logic [WIDTH-1:0]  data;
    logic              rd_valid;
    logic              busy;

    modport master (
        output addr, wr_en, wr_data, rd_en, oe_n,
        input  data, rd_valid, busy
    );

    modport slave (
        input  addr, wr_en, wr_data, rd_en, oe_n,
        output data, rd_valid, busy
    );
endinterface

// File: rtl/sync_mem.sv
// ----------------------------------------------------------------------------
// sync_mem : single-port synchronous RAM with registered read data, a write
// port and an active-low output enable onto a shared tri-state bus.
// After every reset a sweep engine writes the whole array (DEPTH cycles)
// while 'busy' is high; port accesses are ignored during the sweep.
//
// Optional feature macro: MEM_BOOT_EN
//   defined   -> the sweep loads a fixed 16-byte boot image into addresses
//                0x0-0xF (zero-extended to WIDTH, WIDTH must be >= 8);
//                higher addresses still receive INIT_VAL.
//   undefined -> every location receives INIT_VAL.
// ----------------------------------------------------------------------------
module sync_mem #(
    parameter int               WIDTH    = 8,
    parameter int               ADDR_W   = 4,
    parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b0}}
) (
    input  logic       clk,
    input  logic       reset,
    sync_mem_if.slave  bus
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    logic [WIDTH-1:0]  mem_r [DEPTH];

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;
    logic              busy_r;
    logic              busy_nxt_s;
    logic [WIDTH-1:0]  rd_q_r;
    logic              rd_valid_r;

    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [WIDTH-1:0]  mem_wdata_s;
    logic              rd_accept_s;
    logic [WIDTH-1:0]  sweep_word_s;

`ifdef MEM_BOOT_EN
    // Boot image lookup: low byte from the table, upper bits zero; beyond
    // the table the plain init value is used.
    function automatic logic [WIDTH-1:0] boot_word(input logic [ADDR_W-1:0] a);
        logic [7:0]       b;
        logic [WIDTH-1:0] w;
        int               idx;
        idx = int'(a);
        case (idx)
            0:       b = 8'h08;
            1:       b = 8'h19;
            2:       b = 8'h88;
            3:       b = 8'h2A;
            4:       b = 8'h88;
            5:       b = 8'h6C;
            6:       b = 8'h50;
            7:       b = 8'h50;
            8:       b = 8'h89;
            9:       b = 8'h08;
            10:      b = 8'h01;
            11:      b = 8'h80;
            12:      b = 8'h0F;
            13:      b = 8'h88;
            14:      b = 8'h70;
            15:      b = 8'hFF;
            default: b = 8'h00;
        endcase
        if (idx < 16) begin
            w = WIDTH'(b);
        end else begin
            w = INIT_VAL;
        end
        return w;
    endfunction

    assign sweep_word_s = boot_word(cnt_r);
`else
    assign sweep_word_s = INIT_VAL;
`endif

    // Next-state, sweep counter and array-write selection.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        busy_nxt_s  = busy_r;
        mem_we_s    = 1'b0;
        mem_waddr_s = bus.addr;
        mem_wdata_s = bus.wr_data;
        rd_accept_s = 1'b0;
        if (reset) begin
            state_nxt_s = ST_INIT;
            cnt_nxt_s   = {ADDR_W{1'b0}};
            busy_nxt_s  = 1'b1;
        end else begin
            case (state_r)
                ST_INIT: begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = cnt_r;
                    mem_wdata_s = sweep_word_s;
                    cnt_nxt_s   = cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_ADDR) begin
                        state_nxt_s = ST_IDLE;
                        busy_nxt_s  = 1'b0;
                    end else begin
                        state_nxt_s = ST_INIT;
                        busy_nxt_s  = 1'b1;
                    end
                end
                ST_IDLE: begin
                    mem_we_s    = bus.wr_en;
                    rd_accept_s = bus.rd_en;
                end
                default: begin
                    state_nxt_s = ST_INIT;
                    cnt_nxt_s   = {ADDR_W{1'b0}};
                    busy_nxt_s  = 1'b1;
                end
            endcase
        end
    end

    // Control state: FSM, sweep counter and busy flag.
    always_ff @(posedge clk) begin
        state_r <= state_nxt_s;
        cnt_r   <= cnt_nxt_s;
        busy_r  <= busy_nxt_s;
    end

    // Read register and its valid pulse; the array read sees pre-edge
    // contents, which gives read-first behaviour on a same-address write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q_r     <= {WIDTH{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_accept_s;
            if (rd_accept_s) begin
                rd_q_r <= mem_r[bus.addr];
            end
        end
    end

    // Storage array: sweep or port writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign bus.busy     = busy_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.data     = (!bus.oe_n && !busy_r) ? rd_q_r : {WIDTH{1'bz}};

endmodule

// File: tb/tb_sync_mem.sv
// ----------------------------------------------------------------------------
// tb_sync_mem : self-checking bench for sync_mem (ADDR_W=4, INIT_VAL=A5).
// A behavioural model (array + remaining-sweep-cycle count) predicts busy,
// rd_valid and the bus value after every clock edge.
// ----------------------------------------------------------------------------
module tb_sync_mem;

    localparam int         WIDTH  = 8;
    localparam int         ADDR_W = 4;
    localparam int         DEPTH  = 16;
    localparam logic [7:0] INIT   = 8'hA5;
    localparam logic [7:0] BOOT [16] = '{8'h08, 8'h19, 8'h88, 8'h2A,
                                         8'h88, 8'h6C, 8'h50, 8'h50,
                                         8'h89, 8'h08, 8'h01, 8'h80,
                                         8'h0F, 8'h88, 8'h70, 8'hFF};

    logic clk = 1'b0;
    logic reset;

    sync_mem_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus_if ();

    sync_mem #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .INIT_VAL(INIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_rq = 8'h00;
    logic       m_rv = 1'b0;
    int         sweep_left = DEPTH;
    logic [7:0] z_word;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       oe_n;
        logic [3:0] addr;
        logic [7:0] wd;
        logic       exp_rv;
        logic       exp_z;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [7:0] exp_init(input int a);
`ifdef MEM_BOOT_EN
        return BOOT[a];
`else
        return INIT;
`endif
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_bus(input logic oe_n);
        return (!oe_n && sweep_left == 0) ? m_rq : z_word;
    endfunction

    // One clock edge: drive inputs, advance the model, compare outputs.
    task automatic step(input logic rst, input logic wr, input logic rd, input logic oe_n,
                        input logic [3:0] a, input logic [7:0] wd);
        reset          = rst;
        bus_if.wr_en   = wr;
        bus_if.rd_en   = rd;
        bus_if.oe_n    = oe_n;
        bus_if.addr    = a;
        bus_if.wr_data = wd;
        @(posedge clk);
        if (rst) begin
            sweep_left = DEPTH;
            m_rq       = 8'h00;
            m_rv       = 1'b0;
        end else if (sweep_left > 0) begin
            sweep_left--;
            m_rv = 1'b0;
            if (sweep_left == 0) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] = exp_init(i);
            end
        end else begin
            m_rv = rd;
            if (rd) m_rq = m_mem[a];
            if (wr) m_mem[a] = wd;
        end
        #1;
        check("busy", 8'(bus_if.busy), 8'(sweep_left > 0));
        check("rd_valid", 8'(bus_if.rd_valid), 8'(m_rv));
        check("data", bus_if.data, exp_bus(oe_n));
    endtask

    task automatic nop(input logic oe_n);
        step(1'b0, 1'b0, 1'b0, oe_n, 4'h0, 8'h00);
    endtask

    // Release from reset and count edges until busy drops (bounded).
    task automatic sweep_len(input string name, input logic scribble);
        int n;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, scribble, scribble, 1'b0, 4'($urandom_range(0, 15)), 8'h5A);
            n++;
            if (!bus_if.busy) break;
        end
        check(name, 8'(n), 8'd16);
    endtask

    initial begin
        z_word = {WIDTH{1'bz}};
        bus_if.wr_en = 1'b0; bus_if.rd_en = 1'b0; bus_if.oe_n = 1'b0;
        bus_if.addr = 4'h0; bus_if.wr_data = 8'h00; reset = 1'b1;

        tbl[0] = '{1'b1, 1'b0, 1'b1, 4'h7, 8'h3C, 1'b0, 1'b1, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 4'h7, 8'h00, 1'b1, 1'b0, 8'h3C};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h3C};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h3C};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 4'h2, 8'h11, 1'b0, 1'b1, 8'h00};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 4'h2, 8'h22, 1'b1, 1'b0, 8'h11};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 4'h2, 8'h00, 1'b1, 1'b0, 8'h22};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h22};

        // Reset for two cycles, then the sweep must last exactly 16 edges.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        sweep_len("sweep_len", 1'b0);

        // Reads of the first and last location after the sweep.
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00);
        check("rd_0x0", bus_if.data, exp_init(0));
        nop(1'b0);
        check("rv_drop", 8'(bus_if.rd_valid), 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 8'h00);
        check("rd_0xF", bus_if.data, exp_init(15));

        // Table: write/read, output enable, read-during-write.
        for (int i = 0; i < 9; i++) begin
            step(1'b0, tbl[i].wr, tbl[i].rd, tbl[i].oe_n, tbl[i].addr, tbl[i].wd);
            check($sformatf("tbl%0d_rv", i), 8'(bus_if.rd_valid), 8'(tbl[i].exp_rv));
            check($sformatf("tbl%0d_data", i), bus_if.data,
                  tbl[i].exp_z ? z_word : tbl[i].exp_data);
            if (i == 2) begin
                // Combinational output enable, no clock edge in between.
                bus_if.oe_n = 1'b1; #1;
                check("oe_off_z", bus_if.data, z_word);
                bus_if.oe_n = 1'b0; #1;
                check("oe_on_data", bus_if.data, 8'h3C);
                check("oe_no_rv", 8'(bus_if.rd_valid), 8'h00);
            end
        end

        // Reset at sweep cycle 5 with port writes during busy.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'(k), 8'hC3);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 8'hC3);
        sweep_len("resweep_len", 1'b1);
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 4'(a), 8'h00);
            check($sformatf("readback_%0h", a), bus_if.data, exp_init(a));
        end

        // Randomised traffic against the model, with occasional resets.
        for (int k = 0; k < 500; k++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), 4'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
